fetch_queue: RTL and testbench

Parametrised instruction fetch queue between the IF and ID stages of the five-stage LoongArch pipeline. It generalises the single-register valid/allowin stage boundary into a DEPTH-entry FIFO, so IF can run ahead while ID stalls. It also supports flush on a writeback exception/ertn redirect and an optional zero-latency bypass. Both sides use the pipeline's existing valid/allowin handshake.

---
 rtl/fetch_queue_pkg.sv | 8 +
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue_mem.sv | 17 +
 rtl/fetch_queue.sv | 57 +++++
 tb/tb_fetch_queue.sv | 117 +++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared sizing for the IF->ID fetch queue
package fetch_queue_pkg;
  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int FQ_DEPTH = 4;
  function automatic int fq_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: IF-side and ID-side valid/allowin handshake plus occupancy status
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH = FS_TO_DS_BUS_WD,
  parameter int DEPTH = FQ_DEPTH
);
  localparam int CW = fq_cw(DEPTH);
  logic             in_valid;
  logic             in_allowin;
  logic [WIDTH-1:0] in_bus;
  logic             out_valid;
  logic             out_allowin;
  logic [WIDTH-1:0] out_bus;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  modport slave (
    input  in_valid, in_bus, out_allowin,
    output in_allowin, out_valid, out_bus, count, full, empty
  );
  modport master (
    output in_valid, in_bus, out_allowin,
    input  in_allowin, out_valid, out_bus, count, full, empty
  );
endinterface

// File: rtl/fetch_queue_mem.sv
// fq_mem: DEPTH x WIDTH storage, synchronous write, asynchronous read, data never reset
module fq_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  always_comb rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry IF->ID FIFO with flush and optional empty-queue bypass
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH  = FS_TO_DS_BUS_WD,
  parameter int DEPTH  = FQ_DEPTH,
  parameter bit BYPASS = 1'b0
) (
  input logic        clk,
  input logic        reset,
  input logic        flush,
  fetch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = fq_cw(DEPTH);
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_data;
  logic             empty, full, push, pop, byp_con, wr_en, rd_en;
  fq_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_q),
    .wdata_i (q.in_bus),
    .raddr_i (rd_q),
    .rdata_o (rd_data)
  );
  // allowin looks only at registered state, so ID never combinationally gates IF
  always_comb begin
    empty        = cnt_q == '0;
    full         = cnt_q == CW'(DEPTH);
    q.in_allowin = ~full & ~reset;
    q.out_valid  = (~empty | (BYPASS & q.in_valid)) & ~flush & ~reset;
    q.out_bus    = (BYPASS && empty) ? q.in_bus : rd_data;
    q.count      = cnt_q;
    q.full       = full;
    q.empty      = empty;
    push         = q.in_valid & q.in_allowin & ~flush;
    pop          = q.out_valid & q.out_allowin;
    byp_con      = BYPASS & empty & push & pop;
    wr_en        = push & ~byp_con;
    rd_en        = pop & ~byp_con;
    wr_d         = wr_q + AW'(wr_en);
    rd_d         = rd_q + AW'(rd_en);
    cnt_d        = cnt_q + CW'(wr_en) - CW'(rd_en);
  end
  always_ff @(posedge clk)
    if (reset | flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: BYPASS=0 and BYPASS=1 queues driven in lockstep against a queue-based model
module tb_fetch_queue;
  localparam int D = 4;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_allowin;
  logic [63:0] in_bus;
  int          checks = 0, errors = 0;
  logic [63:0] mq [2][$];
  logic        o_allow [2], o_valid [2], o_full [2], o_empty [2];
  logic [63:0] o_bus [2];
  logic [2:0]  o_cnt [2];

  always #5 clk = ~clk;

  fetch_queue_if #(.WIDTH(64), .DEPTH(D)) f0 ();
  fetch_queue_if #(.WIDTH(64), .DEPTH(D)) f1 ();
  fetch_queue #(.WIDTH(64), .DEPTH(D), .BYPASS(1'b0)) u0 (.clk(clk), .reset(reset), .flush(flush), .q(f0));
  fetch_queue #(.WIDTH(64), .DEPTH(D), .BYPASS(1'b1)) u1 (.clk(clk), .reset(reset), .flush(flush), .q(f1));

  assign f0.in_valid = in_valid;
  assign f0.in_bus = in_bus;
  assign f0.out_allowin = out_allowin;
  assign f1.in_valid = in_valid;
  assign f1.in_bus = in_bus;
  assign f1.out_allowin = out_allowin;
  assign o_allow[0] = f0.in_allowin;
  assign o_allow[1] = f1.in_allowin;
  assign o_valid[0] = f0.out_valid;
  assign o_valid[1] = f1.out_valid;
  assign o_bus[0] = f0.out_bus;
  assign o_bus[1] = f1.out_bus;
  assign o_cnt[0] = f0.count;
  assign o_cnt[1] = f1.count;
  assign o_full[0] = f0.full;
  assign o_full[1] = f1.full;
  assign o_empty[0] = f0.empty;
  assign o_empty[1] = f1.empty;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // one cycle: drive at posedge+1, compare at negedge, advance the model at the edge
  task automatic step(input logic r, input logic fl, input logic iv, input logic [63:0] b, input logic oa);
    reset = r;
    flush = fl;
    in_valid = iv;
    in_bus = b;
    out_allowin = oa;
    #4;
    for (int i = 0; i < 2; i++) begin
      int  n = mq[i].size();
      logic ev = !r && !fl && (n > 0 || (i == 1 && iv));
      string p = $sformatf("byp%0d_", i);
      chk({p, "in_allowin"}, 64'(o_allow[i]), 64'(n < D && !r));
      chk({p, "out_valid"}, 64'(o_valid[i]), 64'(ev));
      chk({p, "count"}, 64'(o_cnt[i]), 64'(n));
      chk({p, "full"}, 64'(o_full[i]), 64'(n == D));
      chk({p, "empty"}, 64'(o_empty[i]), 64'(n == 0));
      if (ev) chk({p, "out_bus"}, o_bus[i], n > 0 ? mq[i][0] : b);
      if (r || fl) mq[i].delete();
      else begin
        bit pu = iv && n < D;
        bit po = ev && oa;
        if (po && n > 0) void'(mq[i].pop_front());
        if (pu && !(po && n == 0)) mq[i].push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_bus = '0;
    out_allowin = 1'b0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) step(0, 0, 1, 64'hA0 + 64'(r * 16 + k), 0);
      for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1);
    end
    step(0, 0, 1, 64'hB1, 0);
    step(0, 0, 1, 64'hB2, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 64'hC0 + 64'(k), 1);
    step(0, 0, 1, 64'hD0, 0);
    step(0, 1, 1, 64'hDEAD, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 64'h1c000000_02800400, 1);
    step(0, 0, 1, 64'h1c000000_02800404, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 64'hE1, 0);
    step(0, 0, 1, 64'hE2, 0);
    step(1, 0, 1, 64'hE3, 1);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      int ph = (k / 200) % 3;
      step($urandom_range(63) == 0, $urandom_range(15) == 0,
           ph == 1 ? $urandom_range(3) == 0 : $urandom_range(3) != 0, rnd64(),
           ph == 2 ? $urandom_range(3) == 0 : $urandom_range(1) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
